// File: rtl/pu_result_collector.sv
// -----------------------------------------------------------------------------
// pu_result_collector
//
// Drains the per-PU result registers after each compute round and streams the
// words, in raster order, to the output feature map (OFM) write port over a
// valid/ready handshake. One start covers a full NUM_ROUNDS x NUM_PU map.
//
// Each word goes through RD (read strobe) -> CAP (capture PU data and address)
// -> HOLD (offer to OFM until accepted), so an unstalled stream moves one word
// every three cycles. A round_done that arrives while a round is still being
// drained is remembered in a one-deep pending flag. A second early pulse
// cannot be remembered and raises the sticky err_overrun flag.
//
// Ports
//   clk          in   rising-edge clock
//   nrst         in   asynchronous active-low reset
//   start        in   one-cycle pulse, begins a frame (IDLE only)
//   round_done   in   one-cycle pulse, a round of PU results is stable
//   pu_rd_en     out  PU result read strobe
//   pu_sel       out  PU index being read
//   pu_rd_data   in   PU result, valid the cycle after pu_rd_en
//   ofm_valid    out  OFM write request
//   ofm_ready    in   OFM accepts the request
//   ofm_addr     out  round_cnt*NUM_PU + pu_sel of the word on offer
//   ofm_data     out  word on offer
//   round_cnt    out  current round index
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse at frame end
//   err_overrun  out  sticky, a round_done was lost
// -----------------------------------------------------------------------------
module pu_result_collector #(
  parameter int NUM_PU     = 28,
  parameter int NUM_ROUNDS = 28,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              round_done,
  output logic              pu_rd_en,
  output logic [5:0]        pu_sel,
  input  logic [DATA_W-1:0] pu_rd_data,
  output logic              ofm_valid,
  input  logic              ofm_ready,
  output logic [ADDR_W-1:0] ofm_addr,
  output logic [DATA_W-1:0] ofm_data,
  output logic [5:0]        round_cnt,
  output logic              busy,
  output logic              done,
  output logic              err_overrun
);

  localparam logic [5:0] PU_LAST  = 6'(NUM_PU - 1);
  localparam logic [5:0] RND_LAST = 6'(NUM_ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RND,
    S_RD,
    S_CAP,
    S_HOLD,
    S_FINISH
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [5:0]          r_pu_sel;
  logic [5:0]          w_pu_sel_nxt;
  logic [5:0]          r_round_cnt;
  logic [5:0]          w_round_cnt_nxt;
  logic                r_pending;
  logic                w_pending_nxt;
  logic                r_err;
  logic                w_err_nxt;
  logic [ADDR_W-1:0]   r_ofm_addr;
  logic [ADDR_W-1:0]   w_ofm_addr_nxt;
  logic [DATA_W-1:0]   r_ofm_data;
  logic [DATA_W-1:0]   w_ofm_data_nxt;
  logic                w_draining;

  // Raster address of a word; the parameter rule guarantees the product fits
  // in ADDR_W bits, so it is formed directly at that width.
  function automatic logic [ADDR_W-1:0] f_ofm_addr(input logic [5:0] rnd,
                                                    input logic [5:0] sel);
    return ADDR_W'(rnd) * ADDR_W'(NUM_PU) + ADDR_W'(sel);
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= S_IDLE;
      r_pu_sel    <= '0;
      r_round_cnt <= '0;
      r_pending   <= 1'b0;
      r_err       <= 1'b0;
      r_ofm_addr  <= '0;
      r_ofm_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pu_sel    <= w_pu_sel_nxt;
      r_round_cnt <= w_round_cnt_nxt;
      r_pending   <= w_pending_nxt;
      r_err       <= w_err_nxt;
      r_ofm_addr  <= w_ofm_addr_nxt;
      r_ofm_data  <= w_ofm_data_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt     = r_state;
    w_pu_sel_nxt    = r_pu_sel;
    w_round_cnt_nxt = r_round_cnt;
    w_pending_nxt   = r_pending;
    w_err_nxt       = r_err;
    w_ofm_addr_nxt  = r_ofm_addr;
    w_ofm_data_nxt  = r_ofm_data;

    w_draining = (r_state == S_RD) || (r_state == S_CAP) ||
                 (r_state == S_HOLD) || (r_state == S_FINISH);

    // An early round_done is parked in the pending flag; a second one while
    // the flag is still full is lost and reported.
    if (round_done && w_draining) begin
      if (r_pending) begin
        w_err_nxt = 1'b1;
      end else begin
        w_pending_nxt = 1'b1;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt     = S_WAIT_RND;
          w_round_cnt_nxt = '0;
          w_pu_sel_nxt    = '0;
          w_pending_nxt   = 1'b0;
          w_err_nxt       = 1'b0;
        end
      end

      S_WAIT_RND: begin
        if (round_done) begin
          w_state_nxt  = S_RD;
          w_pu_sel_nxt = '0;
        end
      end

      S_RD: begin
        w_state_nxt = S_CAP;
      end

      S_CAP: begin
        w_ofm_data_nxt = pu_rd_data;
        w_ofm_addr_nxt = f_ofm_addr(r_round_cnt, r_pu_sel);
        w_state_nxt    = S_HOLD;
      end

      S_HOLD: begin
        if (ofm_ready) begin
          if (r_pu_sel != PU_LAST) begin
            w_pu_sel_nxt = r_pu_sel + 6'd1;
            w_state_nxt  = S_RD;
          end else begin
            w_pu_sel_nxt = '0;
            if (r_round_cnt == RND_LAST) begin
              w_state_nxt = S_FINISH;
            end else begin
              // Round boundary: the next round starts immediately if a
              // round_done is parked or arrives right now. A coincident pulse
              // with the flag full replaces the consumed one, so no error.
              w_round_cnt_nxt = r_round_cnt + 6'd1;
              w_err_nxt       = r_err;
              if (r_pending) begin
                w_state_nxt   = S_RD;
                w_pending_nxt = round_done;
              end else if (round_done) begin
                w_state_nxt   = S_RD;
                w_pending_nxt = 1'b0;
              end else begin
                w_state_nxt   = S_WAIT_RND;
                w_pending_nxt = 1'b0;
              end
            end
          end
        end
      end

      S_FINISH: begin
        // A round announced after the last round has nowhere to go.
        if (r_pending) begin
          w_err_nxt = 1'b1;
        end
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign pu_rd_en    = (r_state == S_RD);
  assign ofm_valid   = (r_state == S_HOLD);
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_FINISH);
  assign pu_sel      = r_pu_sel;
  assign round_cnt   = r_round_cnt;
  assign ofm_addr    = r_ofm_addr;
  assign ofm_data    = r_ofm_data;
  assign err_overrun = r_err;

endmodule

// File: tb/tb_pu_result_collector.sv
// -----------------------------------------------------------------------------
// tb_pu_result_collector
//
// Scoreboard bench for pu_result_collector. Every round_done the bench issues
// for a new round pushes that round's NUM_PU expected (address, data) words;
// the monitor pops and compares one entry per OFM handshake. The PU array is
// modelled as a registered source whose value is a fixed function of a
// per-frame salt, the round and the PU index.
// -----------------------------------------------------------------------------
module tb_pu_result_collector;

  localparam int NUM_PU     = 28;
  localparam int NUM_ROUNDS = 28;
  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 10;
  localparam int WORDS      = NUM_PU * NUM_ROUNDS;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              clk        = 1'b0;
  logic              nrst       = 1'b0;
  logic              start      = 1'b0;
  logic              round_done = 1'b0;
  logic              ofm_ready  = 1'b1;
  logic [DATA_W-1:0] pu_rd_data = '0;
  logic              pu_rd_en;
  logic              ofm_valid;
  logic              busy;
  logic              done;
  logic              err_overrun;
  logic [5:0]        pu_sel;
  logic [5:0]        round_cnt;
  logic [ADDR_W-1:0] ofm_addr;
  logic [DATA_W-1:0] ofm_data;

  int          n_err      = 0;
  int          n_chk      = 0;
  int          hs_cnt     = 0;
  int          done_cnt   = 0;
  int          next_round = 0;
  logic [15:0] salt       = 16'h1000;
  exp_t        sb_q[$];
  exp_t        mon_e;

  always #5 clk = ~clk;

  pu_result_collector #(
    .NUM_PU    (NUM_PU),
    .NUM_ROUNDS(NUM_ROUNDS),
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W)
  ) u_dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .round_done (round_done),
    .pu_rd_en   (pu_rd_en),
    .pu_sel     (pu_sel),
    .pu_rd_data (pu_rd_data),
    .ofm_valid  (ofm_valid),
    .ofm_ready  (ofm_ready),
    .ofm_addr   (ofm_addr),
    .ofm_data   (ofm_data),
    .round_cnt  (round_cnt),
    .busy       (busy),
    .done       (done),
    .err_overrun(err_overrun)
  );

  function automatic logic [DATA_W-1:0] pu_val(input logic [15:0] s, input int r, input int p);
    return DATA_W'(int'(s) + r * 1031 + p * 97 + ((r ^ p) << 11));
  endfunction

  // PU array: result appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (pu_rd_en) pu_rd_data <= pu_val(salt, int'(round_cnt), int'(pu_sel));
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Monitor: compare every accepted OFM word against the scoreboard.
  always @(negedge clk) begin
    if (nrst) begin
      if (done) done_cnt++;
      if (ofm_valid && ofm_ready) begin
        hs_cnt++;
        if (sb_q.size() == 0) begin
          check("unexpected_word", 32'(ofm_addr), 32'hFFFF_FFFF);
        end else begin
          mon_e = sb_q.pop_front();
          check("ofm_addr", 32'(ofm_addr), 32'(mon_e.addr));
          check("ofm_data", 32'(ofm_data), 32'(mon_e.data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rd();
    round_done = 1'b1;
    tick();
    round_done = 1'b0;
  endtask

  task automatic push_round();
    exp_t e;
    for (int p = 0; p < NUM_PU; p++) begin
      e.addr = ADDR_W'(next_round * NUM_PU + p);
      e.data = pu_val(salt, next_round, p);
      sb_q.push_back(e);
    end
    next_round++;
  endtask

  task automatic wait_hold(input int a);
    int n = 0;
    while (!(ofm_valid && ofm_addr == ADDR_W'(a)) && n < 3000) begin
      tick();
      n++;
    end
    check("hold_seen", 32'({ofm_valid, ofm_addr}), 32'({1'b1, ADDR_W'(a)}));
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb_q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    check("round_drained", sb_q.size(), 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check("done_seen", 32'(done), 1);
  endtask

  task automatic run_rounds(input int upto);
    while (next_round < upto) begin
      wait_empty();
      push_round();
      pulse_rd();
    end
  endtask

  task automatic do_start(input logic [15:0] s);
    salt       = s;
    hs_cnt     = 0;
    done_cnt   = 0;
    next_round = 0;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_err_clr", 32'(err_overrun), 0);
    check("start_round", 32'(round_cnt), 0);
  endtask

  task automatic end_frame(input int exp_err);
    wait_done();
    tick();
    tick();
    check("frame_words", hs_cnt, WORDS);
    check("frame_done_cnt", done_cnt, 1);
    check("frame_sb_left", sb_q.size(), 0);
    check("frame_err", 32'(err_overrun), 32'(exp_err));
    check("frame_idle", 32'(busy), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 32'({pu_rd_en, ofm_valid, busy, done, err_overrun, pu_sel, round_cnt}), 0);
    check({tag, "_addr"}, 32'(ofm_addr), 0);
    check({tag, "_data"}, 32'(ofm_data), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state, and round_done ignored in IDLE.
    repeat (3) tick();
    check_all_zero("reset_outs");
    nrst = 1'b1;
    tick();
    pulse_rd();
    tick();
    check("idle_ignores_round_done", 32'(busy), 0);

    // Frame 1: coincident pulse, early pulse, backpressure, overrun.
    do_start(16'h1000);
    push_round();
    pulse_rd();
    wait_hold(NUM_PU - 1);
    push_round();
    round_done = 1'b1;
    tick();
    round_done = 1'b0;
    check("simul_rd_en", 32'(pu_rd_en), 1);
    check("simul_round", 32'(round_cnt), 1);
    check("simul_pu_sel", 32'(pu_sel), 0);

    run_rounds(3);
    wait_hold(2 * NUM_PU + 10);
    push_round();
    pulse_rd();
    wait_hold(3 * NUM_PU - 1);
    tick();
    check("early_no_wait_rd_en", 32'(pu_rd_en), 1);
    check("early_round", 32'(round_cnt), 3);
    check("early_err", 32'(err_overrun), 0);

    wait_hold(3 * NUM_PU + 4);
    tick();
    ofm_ready = 1'b0;
    for (int n = 0; n < 10 && !ofm_valid; n++) tick();
    check("stall_valid", 32'(ofm_valid), 1);
    for (int i = 0; i < 10; i++) begin
      check("stall_addr", 32'(ofm_addr), 3 * NUM_PU + 5);
      check("stall_data", 32'(ofm_data), 32'(pu_val(salt, 3, 5)));
      check("stall_no_rd_en", 32'(pu_rd_en), 0);
      tick();
    end
    ofm_ready = 1'b1;

    run_rounds(5);
    wait_hold(4 * NUM_PU + 3);
    push_round();
    pulse_rd();
    check("pending_no_err", 32'(err_overrun), 0);
    wait_hold(4 * NUM_PU + 8);
    pulse_rd();
    check("overrun_err", 32'(err_overrun), 1);
    run_rounds(NUM_ROUNDS);
    end_frame(1);

    // Frame 2: nominal, start while busy, pending left at frame end.
    do_start(16'h2B00);
    run_rounds(6);
    wait_hold(5 * NUM_PU + 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_round", 32'(round_cnt), 5);
    check("busy_start_sel", 32'(pu_sel), 3);
    check("busy_start_busy", 32'(busy), 1);
    run_rounds(NUM_ROUNDS);
    check("nominal_err", 32'(err_overrun), 0);
    wait_hold((NUM_ROUNDS - 1) * NUM_PU + 5);
    pulse_rd();
    check("last_pending_no_err", 32'(err_overrun), 0);
    end_frame(1);

    // Frame 3: reset mid-frame, then a clean restart from address 0.
    do_start(16'h3C00);
    run_rounds(8);
    wait_hold(7 * NUM_PU + 12);
    #2;
    nrst = 1'b0;
    #1;
    check_all_zero("midrst_outs");
    sb_q.delete();
    tick();
    nrst = 1'b1;
    tick();
    do_start(16'h4D00);
    push_round();
    pulse_rd();
    wait_hold(0);
    run_rounds(NUM_ROUNDS);
    end_frame(0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
